// File: rtl/geofence_ctrl.sv
// rtl/geofence_ctrl.sv - geofence query sequencer with one shared cross sign unit
//
// geofence_ctrl: takes one object point and six fence vertices, sorts the
// fence by angle about its first vertex, then tests the object against every
// fence edge. All comparisons share one combinational geofence_cross instance.
// The design runs one comparison per cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   en         point-valid strobe; X/Y captured when en=1 and not busy
//   X, Y       point coordinates (unsigned, CW bits)
//   busy       high from the 7th captured point through the valid cycle
//   valid      one-cycle result strobe
//   is_inside  1 = object strictly inside the fence; holds until next result
//
// Optional build macro: GEOFENCE_EARLY_EXIT_EN. When it is defined, the first
// failing edge test ends TEST early with is_inside=0.
//
// geofence_cross: combinational sign of (T-A) x (S-B).
// Its output s is 0 when the cross product is > 0, and 1 when it is <= 0.

module geofence_cross #(
    parameter int CW = 10
) (
    input  logic [CW-1:0] ax,
    input  logic [CW-1:0] ay,
    input  logic [CW-1:0] tx,
    input  logic [CW-1:0] ty,
    input  logic [CW-1:0] bx,
    input  logic [CW-1:0] by,
    input  logic [CW-1:0] sx,
    input  logic [CW-1:0] sy,
    output logic          s
);

    logic [CW-1:0]   dx1, dy1, dx2, dy2;
    logic            negX1, negY1, negX2, negY2;
    logic [2*CW-1:0] mag1, mag2;
    logic            neg1, neg2;
    logic            positive;

    // Each vector component is held as a magnitude plus a sign bit.
    // Both products are therefore unsigned 2*CW-bit values and cannot overflow.
    always_comb begin
        negX1 = (tx < ax);
        negY1 = (ty < ay);
        negX2 = (sx < bx);
        negY2 = (sy < by);
        dx1   = negX1 ? (ax - tx) : (tx - ax);
        dy1   = negY1 ? (ay - ty) : (ty - ay);
        dx2   = negX2 ? (bx - sx) : (sx - bx);
        dy2   = negY2 ? (by - sy) : (sy - by);
        mag1  = {{CW{1'b0}}, dx1} * {{CW{1'b0}}, dy2};
        mag2  = {{CW{1'b0}}, dy1} * {{CW{1'b0}}, dx2};
        // A zero product has no sign, so it never counts as negative.
        neg1  = (negX1 ^ negY2) & (mag1 != '0);
        neg2  = (negY1 ^ negX2) & (mag2 != '0);
        // The cross product is mag1(signed) - mag2(signed). It is > 0 when:
        //   both terms >= 0: mag1 > mag2
        //   term1 >= 0 and term2 < 0: always
        //   term1 < 0 and term2 >= 0: never
        //   both terms < 0: mag1 < mag2
        if (neg1) begin
            positive = neg2 & (mag1 < mag2);
        end else begin
            positive = neg2 | (mag1 > mag2);
        end
        s = ~positive;
    end

endmodule

module geofence_ctrl #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          busy,
    output logic          valid,
    output logic          is_inside
);

    typedef enum logic [2:0] {
        IDLE,
        SORT,
        TEST,
        FINAL,
        DONE
    } stateType;

    stateType      state;
    logic [2:0]    cnt;
    logic [2:0]    sortJ;
    logic [1:0]    sortPass;
    logic [2:0]    testI;
    logic          ok;

    // Index 0 holds the object. Indices 1..6 hold fence points P0..P5.
    logic [CW-1:0] px [0:6];
    logic [CW-1:0] py [0:6];

    logic [2:0]    idxA, idxT, idxS;
    logic [2:0]    lastJ;
    logic          crossS;

    // Operand selection for the single shared cross unit.
    // In SORT, both vectors start at P0 (index 1) and Pj is compared with Pj+1.
    // In TEST, both vectors start at Pi; one points along the edge and the other at the object.
    always_comb begin
        idxA = 3'd0;
        idxT = 3'd0;
        idxS = 3'd0;
        case (state)
            SORT: begin
                idxA = 3'd1;
                idxT = sortJ + 3'd1;
                idxS = sortJ + 3'd2;
            end
            TEST: begin
                idxA = testI + 3'd1;
                idxT = (testI == 3'd5) ? 3'd1 : (testI + 3'd2);
                idxS = 3'd0;
            end
            default: begin
                idxA = 3'd0;
                idxT = 3'd0;
                idxS = 3'd0;
            end
        endcase
    end

    // TEST uses Pi as the base of both vectors, so A and B share one index.
    geofence_cross #(.CW(CW)) u_cross (
        .ax (px[idxA]),
        .ay (py[idxA]),
        .tx (px[idxT]),
        .ty (py[idxT]),
        .bx (px[idxA]),
        .by (py[idxA]),
        .sx (px[idxS]),
        .sy (py[idxS]),
        .s  (crossS)
    );

    // Bubble pass p ends at j = 4 - p. Across the four passes this gives 4+3+2+1 compares.
    assign lastJ = 3'd4 - {1'b0, sortPass};

    // Point storage is not reset, because its contents are don't-care until a full dataset is loaded.
    always_ff @(posedge clk) begin
        if (state == IDLE && en) begin
            px[cnt] <= X;
            py[cnt] <= Y;
        end else if (state == SORT && crossS) begin
            px[idxT] <= px[idxS];
            py[idxT] <= py[idxS];
            px[idxS] <= px[idxT];
            py[idxS] <= py[idxT];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            sortJ     <= 3'd1;
            sortPass  <= 2'd0;
            testI     <= 3'd0;
            ok        <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (cnt == 3'd6) begin
                            cnt      <= 3'd0;
                            busy     <= 1'b1;
                            sortJ    <= 3'd1;
                            sortPass <= 2'd0;
                            state    <= SORT;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                SORT: begin
                    if (sortJ == lastJ) begin
                        sortJ <= 3'd1;
                        if (sortPass == 2'd3) begin
                            testI <= 3'd0;
                            ok    <= 1'b1;
                            state <= TEST;
                        end else begin
                            sortPass <= sortPass + 2'd1;
                        end
                    end else begin
                        sortJ <= sortJ + 3'd1;
                    end
                end
                TEST: begin
                    ok <= ok & ~crossS;
`ifdef GEOFENCE_EARLY_EXIT_EN
                    if (crossS || testI == 3'd5) begin
                        state <= FINAL;
                    end else begin
                        testI <= testI + 3'd1;
                    end
`else
                    if (testI == 3'd5) begin
                        state <= FINAL;
                    end else begin
                        testI <= testI + 3'd1;
                    end
`endif
                end
                // ok now includes the last edge test. Register it onto the outputs.
                FINAL: begin
                    valid     <= 1'b1;
                    is_inside <= ok;
                    state     <= DONE;
                end
                // This is the valid cycle. en is ignored here, and loading resumes on the next cycle.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_ctrl.sv
// tb/tb_geofence_ctrl.sv - directed self-checking bench for geofence_ctrl

module tb_geofence_ctrl;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          busy;
    logic          valid;
    logic          is_inside;

    int numCompared   = 0;
    int numMismatched = 0;

    // Hexagon fence around (100,100), in scrambled feed order.
    int hexX [6] = '{200, 50, 0, 150, 150, 50};
    int hexY [6] = '{100, 13, 100, 187, 13, 187};
    // Full-range convex hexagon with pivot (0,0).
    int extX [6] = '{0, 300, 1023, 0, 800, 1023};
    int extY [6] = '{0, 1023, 400, 700, 0, 1023};

    geofence_ctrl #(.CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .valid     (valid),
        .is_inside (is_inside)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fenceX(input int sel, input int k);
        return (sel == 0) ? hexX[k] : extX[k];
    endfunction

    function automatic int fenceY(input int sel, input int k);
        return (sel == 0) ? hexY[k] : extY[k];
    endfunction

    task automatic sendPoint(input int x, input int y);
        en = 1'b1;
        X  = x[CW-1:0];
        Y  = y[CW-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic feedSet(input int ox, input int oy, input int sel, input bit gaps, input bit holdEn);
        for (int k = 0; k < 7; k++) begin
            if (k == 0) sendPoint(ox, oy);
            else        sendPoint(fenceX(sel, k - 1), fenceY(sel, k - 1));
            if (gaps && k < 6) begin
                en = 1'b0;
                X  = '1;
                Y  = '1;
                @(posedge clk);
                #1;
            end
        end
        if (holdEn) begin
            en = 1'b1;
            X  = 10'd5;
            Y  = 10'd5;
        end else begin
            en = 1'b0;
        end
    endtask

    // Called at 1 time unit after the edge that captured the 7th point.
    task automatic waitResult(input string tag, input int expInside);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        checkVal({tag, "_busy_start"}, busy, 1);
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) seen = 1'b1;
        end
        checkVal({tag, "_latency"}, lat, 17);
        checkVal({tag, "_inside"}, is_inside, expInside);
        checkVal({tag, "_busy_valid"}, busy, 1);
        @(posedge clk);
        #1;
        checkVal({tag, "_valid_drop"}, valid, 0);
        checkVal({tag, "_busy_drop"}, busy, 0);
        checkVal({tag, "_inside_hold"}, is_inside, expInside);
        en = 1'b0;
    endtask

    task automatic runQuery(input string tag, input int ox, input int oy, input int sel, input int expInside);
        feedSet(ox, oy, sel, 1'b0, 1'b0);
        waitResult(tag, expInside);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        X       = '0;
        Y       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_busy", busy, 0);
        checkVal("reset_valid", valid, 0);
        checkVal("reset_inside", is_inside, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        runQuery("hex_center", 100, 100, 0, 1);
        runQuery("hex_far",    300, 300, 0, 0);
        runQuery("hex_edge",   100, 13,  0, 0);
        runQuery("hex_vertex", 200, 100, 0, 0);

        // Alternate en, then hold en high through busy. The next dataset starts right after valid.
        feedSet(100, 100, 0, 1'b1, 1'b1);
        waitResult("gap_hold", 1);
        feedSet(150, 100, 0, 1'b0, 1'b0);
        waitResult("back2back", 1);
        @(posedge clk);
        #1;

        // Assert reset partway through SORT while is_inside still reads 1 from the last result.
        feedSet(100, 100, 0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("midreset_busy", busy, 0);
        checkVal("midreset_valid", valid, 0);
        checkVal("midreset_inside", is_inside, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        runQuery("after_reset", 150, 100, 0, 1);

        runQuery("ext_mid",      512,  512,  1, 1);
        runQuery("ext_corner_in",1020, 1020, 1, 1);
        runQuery("ext_vertex",   1023, 1023, 1, 0);
        runQuery("ext_cut",      0,    1023, 1, 0);
        runQuery("ext_out_diag", 1000, 100,  1, 0);
        runQuery("ext_in_diag",  900,  200,  1, 1);
        runQuery("ext_on_edge",  1023, 700,  1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
